led_color_sequencer: RTL and testbench

Generates the per-channel duty values (red, green, blue) that the power-LED PWM stage consumes. It sits directly upstream of the PWM driver and is paced by the same prescaler tick. It debounces the user switch and steps through a fixed set of lighting modes on each accepted press. In each mode it produces either static duties or slow ramps, advanced on prescaler ticks.

---
 rtl/led_pkg.sv | 29 ++
 rtl/sw_debounce.sv | 56 +++++
 rtl/led_color_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_led_color_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode type and constants for the LED colour sequencer
//
// Contents:
//   mode_e          lighting mode, 2 bits
//   DUTY_W_DEFAULT  default duty width
//   HUE_PHASES      number of colour-wheel segments
//   next_mode()     press order OFF -> BREATHE -> HUE -> FULL -> OFF
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF,
        MODE_BREATHE,
        MODE_HUE,
        MODE_FULL
    } mode_e;

    localparam int DUTY_W_DEFAULT = 8;
    localparam int HUE_PHASES     = 6;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_OFF:     return MODE_BREATHE;
            MODE_BREATHE: return MODE_HUE;
            MODE_HUE:     return MODE_FULL;
            default:      return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - switch synchronizer, tick-paced debouncer and press detector
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   tick    prescaler strobe that paces the debounce counter
//   sw_in   raw asynchronous switch level
//   stable  debounced switch level
//   rise    one-cycle pulse in the cycle after stable goes high
module sw_debounce #(
    parameter int DEBOUNCE_TICKS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sw_in,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic             sync_0;
    logic             sync_1;
    logic             stable_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0   <= 1'b0;
            sync_1   <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_0   <= sw_in;
            sync_1   <= sync_0;
            stable_q <= stable;
            // Any return to the accepted level restarts the qualification window,
            // so a glitch shorter than DEBOUNCE_TICKS ticks is never accepted.
            if (sync_1 == stable) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                    stable <= sync_1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign rise = stable & ~stable_q;

endmodule

// File: rtl/led_color_sequencer.sv
// rtl/led_color_sequencer.sv - mode FSM and RGB duty generator feeding the LED PWM stage
//
// Ports:
//   clk                    system clock
//   rst                    asynchronous active-high reset
//   tick                   prescaler strobe
//   sw                     raw user switch, pressed = 1
//   duty_r/duty_g/duty_b   registered channel duties
//   update                 pulse in the cycle any duty output changed
//   mode                   current lighting mode
module led_color_sequencer
    import led_pkg::*;
#(
    parameter int DUTY_W         = DUTY_W_DEFAULT,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int STEP_TICKS     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              sw,
    output logic [DUTY_W-1:0] duty_r,
    output logic [DUTY_W-1:0] duty_g,
    output logic [DUTY_W-1:0] duty_b,
    output logic              update,
    output mode_e             mode
);

    localparam logic [DUTY_W-1:0] DMAX = '1;
    localparam int SCNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    logic sw_stable;
    logic sw_rise;
    logic press;

    sw_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .sw_in (sw),
        .stable(sw_stable),
        .rise  (sw_rise)
    );

    // sw_rise already implies sw_stable; the AND only documents the intent.
    assign press = sw_rise & sw_stable;

    // ---------------------------------------------------------------- step pacing
    logic [SCNT_W-1:0] step_cnt;
    logic              step_hit;
    logic              step;

    assign step_hit = tick && (step_cnt == SCNT_W'(STEP_TICKS - 1));
    // A press landing on a step tick wins: the mode changes and no step is taken.
    assign step     = step_hit && !press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (press) begin
            step_cnt <= '0;
        end else if (tick) begin
            step_cnt <= step_hit ? '0 : step_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------- mode FSM
    mode_e mode_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= MODE_OFF;
        end else begin
            mode <= mode_next;
        end
    end

    always_comb begin
        mode_next = mode;
        if (press) begin
            mode_next = next_mode(mode);
        end
    end

    // ---------------------------------------------------------------- animation state
    logic [DUTY_W-1:0] level;
    logic [DUTY_W-1:0] level_n;
    logic              dir_up;
    logic              dir_up_n;
    logic [2:0]        phase;
    logic [2:0]        phase_n;
    logic [DUTY_W-1:0] ramp;
    logic [DUTY_W-1:0] ramp_n;

    always_comb begin
        level_n  = level;
        dir_up_n = dir_up;
        phase_n  = phase;
        ramp_n   = ramp;
        if (press) begin
            // Every mode change restarts both animations from their origin.
            level_n  = '0;
            dir_up_n = 1'b1;
            phase_n  = 3'd0;
            ramp_n   = '0;
        end else if (step) begin
            case (mode)
                MODE_BREATHE: begin
                    // Direction flips on the step that lands on a bound, so
                    // the level peaks at DMAX and bottoms at 0 without wrapping.
                    if (dir_up) begin
                        level_n = level + 1'b1;
                        if (level_n == DMAX) dir_up_n = 1'b0;
                    end else begin
                        level_n = level - 1'b1;
                        if (level_n == '0) dir_up_n = 1'b1;
                    end
                end
                MODE_HUE: begin
                    if (ramp == DMAX) begin
                        ramp_n  = '0;
                        phase_n = (phase == 3'(HUE_PHASES - 1)) ? 3'd0 : phase + 3'd1;
                    end else begin
                        ramp_n = ramp + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level  <= '0;
            dir_up <= 1'b1;
            phase  <= 3'd0;
            ramp   <= '0;
        end else begin
            level  <= level_n;
            dir_up <= dir_up_n;
            phase  <= phase_n;
            ramp   <= ramp_n;
        end
    end

    // ---------------------------------------------------------------- duty targets
    // Targets use the next animation values so a step shows on the duty outputs
    // at the same edge. On a press the duties hold; the new mode's colours are
    // registered one clock after mode changes.
    logic [DUTY_W-1:0] r_n;
    logic [DUTY_W-1:0] g_n;
    logic [DUTY_W-1:0] b_n;

    always_comb begin
        r_n = duty_r;
        g_n = duty_g;
        b_n = duty_b;
        if (!press) begin
            case (mode)
                MODE_OFF: begin
                    r_n = '0;
                    g_n = '0;
                    b_n = '0;
                end
                MODE_FULL: begin
                    r_n = DMAX;
                    g_n = DMAX;
                    b_n = DMAX;
                end
                MODE_BREATHE: begin
                    r_n = level_n;
                    g_n = level_n;
                    b_n = level_n;
                end
                MODE_HUE: begin
                    case (phase_n)
                        3'd0:    begin r_n = DMAX;          g_n = ramp_n;        b_n = '0;            end
                        3'd1:    begin r_n = DMAX - ramp_n; g_n = DMAX;          b_n = '0;            end
                        3'd2:    begin r_n = '0;            g_n = DMAX;          b_n = ramp_n;        end
                        3'd3:    begin r_n = '0;            g_n = DMAX - ramp_n; b_n = DMAX;          end
                        3'd4:    begin r_n = ramp_n;        g_n = '0;            b_n = DMAX;          end
                        3'd5:    begin r_n = DMAX;          g_n = '0;            b_n = DMAX - ramp_n; end
                        default: begin r_n = '0;            g_n = '0;            b_n = '0;            end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_r <= '0;
            duty_g <= '0;
            duty_b <= '0;
            update <= 1'b0;
        end else begin
            duty_r <= r_n;
            duty_g <= g_n;
            duty_b <= b_n;
            update <= ({r_n, g_n, b_n} != {duty_r, duty_g, duty_b});
        end
    end

endmodule

// File: tb/tb_led_color_sequencer.sv
// tb/tb_led_color_sequencer.sv - self-checking bench for led_color_sequencer
module tb_led_color_sequencer;

    localparam int DEB  = 16;
    localparam int STEP = 4;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       sw;
    logic [7:0] duty_r;
    logic [7:0] duty_g;
    logic [7:0] duty_b;
    logic       update;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    led_color_sequencer #(
        .DUTY_W        (8),
        .DEBOUNCE_TICKS(DEB),
        .STEP_TICKS    (STEP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .sw    (sw),
        .duty_r(duty_r),
        .duty_g(duty_g),
        .duty_b(duty_b),
        .update(update),
        .mode  (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    // Reference model: switch path as delay line + counted ticks, colours as a
    // closed-form function of steps taken since the mode was entered.
    bit         syn0, syn1;
    bit         m_stable, m_pend, m_upd;
    int         m_dcnt, m_mode, m_tim, m_k;
    logic [7:0] m_r, m_g, m_b;

    function automatic logic [23:0] colour(input int md, input int k);
        int x, p, rp;
        case (md)
            1: begin
                x = k % 510;
                if (x > 255) x = 510 - x;
                return {3{x[7:0]}};
            end
            2: begin
                p  = (k / 256) % 6;
                rp = k % 256;
                case (p)
                    0: return {8'hff, rp[7:0], 8'h00};
                    1: return {8'(255 - rp), 8'hff, 8'h00};
                    2: return {8'h00, 8'hff, rp[7:0]};
                    3: return {8'h00, 8'(255 - rp), 8'hff};
                    4: return {rp[7:0], 8'h00, 8'hff};
                    default: return {8'hff, 8'h00, 8'(255 - rp)};
                endcase
            end
            3: return 24'hffffff;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic model_reset();
        syn0 = 0; syn1 = 0; m_stable = 0; m_pend = 0; m_upd = 0;
        m_dcnt = 0; m_mode = 0; m_tim = 0; m_k = 0;
        m_r = 0; m_g = 0; m_b = 0;
    endtask

    task automatic model_edge(input bit t, input bit s);
        bit          acc, rose;
        logic [23:0] c;
        acc  = m_pend;
        rose = 0;
        if (syn1 == m_stable) m_dcnt = 0;
        else if (t) begin
            m_dcnt++;
            if (m_dcnt == DEB) begin
                m_stable = syn1;
                m_dcnt   = 0;
                rose     = syn1;
            end
        end
        m_pend = rose;
        syn1 = syn0;
        syn0 = s;
        if (acc) begin
            m_mode = (m_mode + 1) % 4;
            m_tim  = 0;
            m_k    = 0;
            m_upd  = 0;
        end else begin
            if (t) begin
                m_tim++;
                if (m_tim == STEP) begin
                    m_tim = 0;
                    m_k++;
                end
            end
            c     = colour(m_mode, m_k);
            m_upd = (c != {m_r, m_g, m_b});
            {m_r, m_g, m_b} = c;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s got timeout want event", name);
    endtask

    task automatic cycle(input bit t, input bit s);
        tick = t;
        sw   = s;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(t, s);
        #1;
        chk("model", int'({duty_r, duty_g, duty_b, update, mode}),
            int'({m_r, m_g, m_b, m_upd, m_mode[1:0]}));
    endtask

    task automatic tk(input int n, input bit s);
        for (int i = 0; i < n; i++) begin
            cycle(1, s);
            cycle(0, s);
        end
    endtask

    task automatic wait_release();
        int g;
        g = 0;
        while (m_stable && g < 100) begin
            cycle(0, 0);
            cycle(1, 0);
            g++;
        end
        if (g >= 100) fail("release");
    endtask

    task automatic press_next();
        int g, m0;
        bit ph;
        wait_release();
        m0 = m_mode;
        g  = 0;
        ph = 0;
        while (m_mode == m0 && g < 200) begin
            cycle(ph, 1);
            ph = !ph;
            g++;
        end
        if (g >= 200) fail("press");
        cycle(0, 0);
    endtask

    task automatic run_to_k(input int target);
        int g;
        g = 0;
        while (m_k < target && g < 20000) begin
            cycle(0, 0);
            cycle(1, 0);
            g++;
        end
        if (g >= 20000) fail("run_to_k");
    endtask

    typedef struct {
        int         steps;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    vec_t btab[8];
    vec_t htab[10];

    initial begin
        btab[0] = '{8, 8'd8, 8'd8, 8'd8};
        btab[1] = '{128, 8'd128, 8'd128, 8'd128};
        btab[2] = '{255, 8'd255, 8'd255, 8'd255};
        btab[3] = '{256, 8'd254, 8'd254, 8'd254};
        btab[4] = '{300, 8'd210, 8'd210, 8'd210};
        btab[5] = '{509, 8'd1, 8'd1, 8'd1};
        btab[6] = '{510, 8'd0, 8'd0, 8'd0};
        btab[7] = '{511, 8'd1, 8'd1, 8'd1};

        htab[0] = '{0, 8'd255, 8'd0, 8'd0};
        htab[1] = '{128, 8'd255, 8'd128, 8'd0};
        htab[2] = '{255, 8'd255, 8'd255, 8'd0};
        htab[3] = '{256, 8'd255, 8'd255, 8'd0};
        htab[4] = '{384, 8'd127, 8'd255, 8'd0};
        htab[5] = '{512, 8'd0, 8'd255, 8'd0};
        htab[6] = '{768, 8'd0, 8'd255, 8'd255};
        htab[7] = '{1024, 8'd0, 8'd0, 8'd255};
        htab[8] = '{1280, 8'd255, 8'd0, 8'd255};
        htab[9] = '{1536, 8'd255, 8'd0, 8'd0};

        // reset state
        rst = 1; tick = 0; sw = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_duty", int'({duty_r, duty_g, duty_b}), 0);
        chk("reset_update", int'(update), 0);
        chk("reset_mode", int'(mode), 0);
        rst = 0;
        repeat (4) cycle(0, 0);

        // glitch of 10 ticks is rejected
        tk(10, 1);
        tk(40, 0);
        chk("glitch_mode", int'(mode), 0);

        // exact press latency: 2 sync clocks, 16 ticks, then one clock to mode
        cycle(0, 1);
        cycle(0, 1);
        for (int i = 0; i < DEB - 1; i++) begin
            cycle(1, 1);
            cycle(0, 1);
        end
        cycle(1, 1);
        chk("latency_before", int'(mode), 0);
        cycle(0, 1);
        chk("latency_mode", int'(mode), 1);
        cycle(0, 0);
        chk("breathe_entry", int'({duty_r, duty_g, duty_b}), 0);
        wait_release();

        // breathe bounds
        for (int i = 0; i < 8; i++) begin
            run_to_k(btab[i].steps);
            chk($sformatf("breathe_%0d", btab[i].steps),
                int'({duty_r, duty_g, duty_b}), int'({btab[i].r, btab[i].g, btab[i].b}));
            chk("breathe_update", int'(update), 1);
        end

        // hue wheel
        press_next();
        chk("hue_mode", int'(mode), 2);
        for (int i = 0; i < 10; i++) begin
            run_to_k(htab[i].steps);
            chk($sformatf("hue_%0d", htab[i].steps),
                int'({duty_r, duty_g, duty_b}), int'({htab[i].r, htab[i].g, htab[i].b}));
        end

        // press accepted on the same cycle as the 4th tick of a step period
        repeat (3) begin
            cycle(0, 0);
            cycle(1, 0);
        end
        cycle(0, 1);
        cycle(0, 1);
        for (int i = 0; i < DEB - 1; i++) begin
            cycle(1, 1);
            cycle(0, 1);
        end
        cycle(1, 1);
        cycle(1, 1);
        chk("collide_mode", int'(mode), 3);
        chk("collide_hold", int'({duty_r, duty_g, duty_b}), int'(24'hff0400));
        cycle(0, 0);
        chk("full_duty", int'({duty_r, duty_g, duty_b}), int'(24'hffffff));
        chk("full_update", int'(update), 1);

        // wrap to OFF, then re-enter BREATHE from level 0
        press_next();
        chk("off_mode", int'(mode), 0);
        chk("off_duty", int'({duty_r, duty_g, duty_b}), 0);
        press_next();
        chk("rebreathe_mode", int'(mode), 1);
        chk("rebreathe_duty", int'({duty_r, duty_g, duty_b}), 0);
        run_to_k(1);
        chk("rebreathe_step", int'({duty_r, duty_g, duty_b}), int'(24'h010101));

        // randomized switch and tick activity
        for (int n = 0; n < 300; n++) begin
            bit s;
            int dur;
            s   = 1'($urandom_range(0, 1));
            dur = $urandom_range(1, 40);
            for (int i = 0; i < dur; i++) cycle(1'($urandom_range(0, 1)), s);
        end

        // asynchronous reset from FULL
        for (int i = 0; i < 4 && m_mode != 3; i++) press_next();
        chk("prereset_mode", int'(mode), 3);
        #2 rst = 1;
        model_reset();
        #1;
        chk("async_duty", int'({duty_r, duty_g, duty_b}), 0);
        chk("async_mode", int'(mode), 0);
        chk("async_update", int'(update), 0);
        repeat (3) cycle(0, 0);
        rst = 0;
        tk(40, 0);
        chk("post_reset_mode", int'(mode), 0);
        chk("post_reset_duty", int'({duty_r, duty_g, duty_b}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
